// File: rtl/multi_cycle_controller.sv
// Moore control FSM for the multi-cycle RV32I core: sequences fetch/decode/
// execute/memory/writeback and drives datapath selects, enables and ALU op.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       alu_zero,
  input  logic       alu_lsb,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK,
    S_LUI, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t state, state_nxt;
  logic   pc_w, ir_w, mem_w, reg_w;

  // alt selects sub (funct3 000) or sra (funct3 101)
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pc_w        = 1'b0;
    adr_src     = 1'b0;
    ir_w        = 1'b0;
    mem_w       = 1'b0;
    reg_w       = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        ir_w       = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_w       = 1'b1;
        state_nxt  = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut <= OldPC + imm, consumed later by branch/JAL/AUIPC
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (opcode)
          OP_LOAD:  begin imm_src = IMM_I; state_nxt = S_MEMADR; end
          OP_STORE: begin imm_src = IMM_S; state_nxt = S_MEMADR; end
          OP_R:     state_nxt = S_EXECR;
          OP_I:     begin imm_src = IMM_I; state_nxt = S_EXECI; end
          OP_BR: begin
            imm_src   = IMM_B;
            state_nxt = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
          end
          OP_JAL:   begin imm_src = IMM_J; state_nxt = S_JAL; end
          OP_JALR:  begin imm_src = IMM_I; state_nxt = S_JALR; end
          OP_LUI:   begin imm_src = IMM_U; state_nxt = S_LUI; end
          OP_AUIPC: begin imm_src = IMM_U; state_nxt = S_ALUWB; end
          default:  state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src   = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_w     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec(funct3, funct7b5);
        state_nxt   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec(funct3, funct7b5 && (funct3 == 3'b101));
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        unique case (funct3)
          3'b000:  begin alu_control = ALU_SUB;  pc_w =  alu_zero; end
          3'b001:  begin alu_control = ALU_SUB;  pc_w = !alu_zero; end
          3'b100:  begin alu_control = ALU_SLT;  pc_w =  alu_lsb;  end
          3'b101:  begin alu_control = ALU_SLT;  pc_w = !alu_lsb;  end
          3'b110:  begin alu_control = ALU_SLTU; pc_w =  alu_lsb;  end
          3'b111:  begin alu_control = ALU_SLTU; pc_w = !alu_lsb;  end
          default: pc_w = 1'b0;
        endcase
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_w      = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_w       = 1'b1;
        state_nxt  = S_JALRLINK;
      end
      S_JALRLINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_w      = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        state_nxt = S_ALUWB;
      end
      default: state_nxt = S_ILLEGAL;
    endcase
  end

  // no architectural write may escape in a reset cycle
  assign pc_write  = pc_w  & rst_n;
  assign ir_write  = ir_w  & rst_n;
  assign mem_write = mem_w & rst_n;
  assign reg_write = reg_w & rst_n;
  assign illegal   = (state == S_ILLEGAL);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: directed and random
// instruction streams compared cycle by cycle against a per-instruction model.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, alu_zero, alu_lsb;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       pcw, adr, irw, memw, regw;
    logic [1:0] rs, a, b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } ov_t;

  multi_cycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .alu_zero(alu_zero), .alu_lsb(alu_lsb),
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
      7'b1100011: return !(f3 == 3'd2 || f3 == 3'd3);
      default:    return 1'b0;
    endcase
  endfunction

  // cycle counts per instruction class
  function automatic int cpi(input logic [6:0] op);
    case (op)
      7'b0000011:             return 5;
      7'b1100011, 7'b0010111: return 3;
      default:                return 4;
    endcase
  endfunction

  // arithmetic op from funct3 and the alternate-encoding bit
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] codes [8];
    codes = '{4'b0000, 4'b0010, 4'b0100, 4'b0110, 4'b1000, 4'b1010, 4'b1100, 4'b1110};
    if (alt && f3 == 3'd0) return 4'b0001;
    if (alt && f3 == 3'd5) return 4'b1011;
    return codes[f3];
  endfunction

  // expected outputs in the cyc-th cycle of instruction (op,f3,f7)
  function automatic ov_t model(input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input int cyc,
                                input logic z, input logic l);
    ov_t e;
    e = '0;
    if (cyc == 0) begin
      e.irw = 1; e.pcw = 1; e.b = 2'b10; e.rs = 2'b10;
      return e;
    end
    if (cyc == 1) begin
      e.a = 2'b01; e.b = 2'b01;
      case (op)
        7'b0100011:             e.imm = 3'b001;
        7'b1100011:             e.imm = 3'b010;
        7'b1101111:             e.imm = 3'b011;
        7'b0110111, 7'b0010111: e.imm = 3'b100;
        default:                e.imm = 3'b000;
      endcase
      return e;
    end
    if (!is_legal(op, f3)) begin
      e.ill = 1;
      return e;
    end
    case (op)
      7'b0000011: case (cyc)
        2: begin e.a = 2'b10; e.b = 2'b01; end
        3: e.adr = 1;
        default: begin e.rs = 2'b01; e.regw = 1; end
      endcase
      7'b0100011: if (cyc == 2) begin e.a = 2'b10; e.b = 2'b01; e.imm = 3'b001; end
                  else begin e.adr = 1; e.memw = 1; end
      7'b0110011: if (cyc == 2) begin e.a = 2'b10; e.alu = ref_alu(f3, f7); end
                  else e.regw = 1;
      7'b0010011: if (cyc == 2) begin e.a = 2'b10; e.b = 2'b01; e.alu = ref_alu(f3, f7 && f3 == 3'd5); end
                  else e.regw = 1;
      7'b1100011: begin
        e.a = 2'b10;
        e.alu = (f3[2:1] == 2'b00) ? 4'b0001 : (f3[1] ? 4'b0110 : 4'b0100);
        e.pcw = (f3[2] ? l : z) ^ f3[0];
      end
      7'b1101111: if (cyc == 2) begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1; end
                  else e.regw = 1;
      7'b1100111: if (cyc == 2) begin e.a = 2'b10; e.b = 2'b01; e.rs = 2'b10; e.pcw = 1; end
                  else begin e.a = 2'b01; e.b = 2'b10; e.rs = 2'b10; e.regw = 1; end
      7'b0110111: if (cyc == 2) begin e.a = 2'b11; e.b = 2'b01; e.imm = 3'b100; end
                  else e.regw = 1;
      default: e.regw = 1;
    endcase
    return e;
  endfunction

  // one clock: drive status inputs, compare mid-cycle, advance to just after edge
  task automatic do_cycle(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input int cyc, input int fz, input int fl, input string nm);
    ov_t e, g;
    if (cyc == 0) begin
      opcode = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
    end else begin
      opcode = op; funct3 = f3; funct7b5 = f7;
    end
    alu_zero = (fz < 0) ? 1'($urandom) : fz[0];
    alu_lsb  = (fl < 0) ? 1'($urandom) : fl[0];
    #2;
    e = model(op, f3, f7, cyc, alu_zero, alu_lsb);
    if (!rst_n) begin e.pcw = 0; e.irw = 0; e.memw = 0; e.regw = 0; end
    g = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
         alu_src_a, alu_src_b, imm_src, alu_control, illegal};
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d op=%b f3=%0d f7=%0d got=%h exp=%h",
               nm, cyc, op, f3, f7, g, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int fz, input int fl, input string nm);
    for (int c = 0; c < cpi(op); c++) do_cycle(op, f3, f7, c, fz, fl, nm);
  endtask

  task automatic test_reset;
    rst_n = 0;
    opcode = '0; funct3 = '0; funct7b5 = 0; alu_zero = 0; alu_lsb = 0;
    @(posedge clk); #1;
    do_cycle(7'b0110011, 3'd0, 1'b0, 0, -1, -1, "reset_fetch_gated");
    do_cycle(7'b0110011, 3'd0, 1'b0, 0, -1, -1, "reset_hold");
    rst_n = 1;
  endtask

  task automatic test_directed;
    run_instr(7'b0110011, 3'd0, 1'b0, -1, -1, "add");
    run_instr(7'b0110011, 3'd0, 1'b1, -1, -1, "sub");
    run_instr(7'b0110011, 3'd5, 1'b1, -1, -1, "sra");
    run_instr(7'b0010011, 3'd5, 1'b1, -1, -1, "srai");
    run_instr(7'b0010011, 3'd0, 1'b1, -1, -1, "addi_f7");
    run_instr(7'b0000011, 3'd2, 1'b0, -1, -1, "lw");
    run_instr(7'b0100011, 3'd2, 1'b0, -1, -1, "sw");
    run_instr(7'b1100011, 3'd1, 1'b0,  1, -1, "bne_z1");
    run_instr(7'b1100011, 3'd1, 1'b0,  0, -1, "bne_z0");
    run_instr(7'b1100011, 3'd7, 1'b0, -1,  0, "bgeu_l0");
    run_instr(7'b1101111, 3'd0, 1'b0, -1, -1, "jal");
    run_instr(7'b1100111, 3'd0, 1'b0, -1, -1, "jalr");
    run_instr(7'b0110111, 3'd3, 1'b1, -1, -1, "lui");
    run_instr(7'b0010111, 3'd6, 1'b0, -1, -1, "auipc");
  endtask

  task automatic test_back_to_back;
    logic [6:0] ops [10];
    logic [2:0] bf3 [6];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0110011};
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      op = ops[$urandom_range(0, 9)];
      f3 = (op == 7'b1100011) ? bf3[$urandom_range(0, 5)] : 3'($urandom);
      run_instr(op, f3, 1'($urandom), -1, -1, "random");
    end
  endtask

  task automatic test_illegal(input logic [6:0] op, input logic [2:0] f3, input string nm);
    for (int c = 0; c < 14; c++) do_cycle(op, f3, 1'b0, c, -1, -1, nm);
    rst_n = 0;
    do_cycle(op, f3, 1'b0, 14, -1, -1, "illegal_reset");
    rst_n = 1;
    run_instr(7'b0110011, 3'd4, 1'b0, -1, -1, "after_illegal");
  endtask

  task automatic test_reset_midwrite;
    for (int c = 0; c < 3; c++) do_cycle(7'b0100011, 3'd2, 1'b0, c, -1, -1, "sw_pre");
    rst_n = 0;
    do_cycle(7'b0100011, 3'd2, 1'b0, 3, -1, -1, "sw_reset_gate");
    rst_n = 1;
    run_instr(7'b0000011, 3'd2, 1'b0, -1, -1, "lw_after_reset");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_illegal(7'b1111111, 3'd0, "illegal_op");
    test_illegal(7'b1100011, 3'd2, "illegal_br");
    test_reset_midwrite;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Main control unit for the multi-cycle RV32I core: a Moore state machine that sequences every instruction through fetch, decode, execute, memory and writeback. It decodes the instruction register fields, generates the per-cycle datapath selects and write enables, and produces the 4-bit `alu_control` code the ALU consumes. Branch outcome is resolved from ALU status inputs.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `opcode` input 7: instr[6:0], stable from the cycle after FETCH.
- `funct3` input 3: instr[14:12].
- `funct7b5` input 1: instr[30].
- `alu_zero` input 1: ALU result == 0.
- `alu_lsb` input 1: ALU result[0].
- `pc_write` output 1: PC register load enable.
- `adr_src` output 1: memory address select. 0 = PC, 1 = Result.
- `ir_write` output 1: load IR and OldPC.
- `mem_write` output 1: data memory write strobe.
- `reg_write` output 1: register file write enable.
- `result_src` output 2: Result select. 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `alu_src_a` output 2: ALU A select. 00 = PC, 01 = OldPC, 10 = register A, 11 = zero.
- `alu_src_b` output 2: ALU B select. 00 = register B, 01 = immediate, 10 = constant 4.
- `imm_src` output 3: immediate format. 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `alu_control` output 4: ALU operation code.
  - 0000 = add, 0001 = sub, 0010 = sll, 1010 = srl, 1011 = sra.
  - 0100 = slt, 0110 = sltu, 1000 = xor, 1100 = or, 1110 = and.
- `illegal` output 1: sticky; set when an unsupported instruction is decoded.

## Operation
Unlisted outputs in any state are 0; `alu_control` defaults to add.

States and actions:
- **FETCH**: adr_src=0, ir_write=1, A=00, B=10, add, result_src=10, pc_write=1. Next: DECODE.
- **DECODE**: A=01, B=01, add, imm_src set by opcode (this precomputes OldPC+imm into ALUOut). Next state by opcode:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH; funct3 010/011 → ILLEGAL instead
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → ALUWB (AUIPC: ALUOut already holds OldPC+immU)
  - any other opcode → ILLEGAL
- **MEMADR**: A=10, B=01, add, imm_src I (load) or S (store). Next: MEMREAD for load, MEMWRITE for store.
- **MEMREAD**: adr_src=1, result_src=00. Next: MEMWB.
- **MEMWB**: result_src=01, reg_write=1. Next: FETCH.
- **MEMWRITE**: adr_src=1, result_src=00, mem_write=1. Next: FETCH.
- **EXECR**: A=10, B=00. alu_control by funct3:
  - 000: add, or sub if funct7b5
  - 001: sll; 010: slt; 011: sltu; 100: xor
  - 101: srl, or sra if funct7b5
  - 110: or; 111: and
  - Next: ALUWB.
- **EXECI**: A=10, B=01, imm I. Same funct3 mapping as EXECR, except funct3 000 is always add; funct7b5 is honoured only for funct3 101. Next: ALUWB.
- **ALUWB**: result_src=00, reg_write=1. Next: FETCH.
- **BRANCH**: A=10, B=00, result_src=00. ALU op and taken condition by funct3:
  - beq: sub, taken if alu_zero
  - bne: sub, taken if !alu_zero
  - blt: slt, taken if alu_lsb
  - bge: slt, taken if !alu_lsb
  - bltu: sltu, taken if alu_lsb
  - bgeu: sltu, taken if !alu_lsb
  - pc_write = taken; this is the only Mealy output. Next: FETCH.
- **JAL**: A=01, B=10, add, result_src=00, pc_write=1. Next: ALUWB (writes OldPC+4).
- **JALR**: A=10, B=01, imm I, add, result_src=10, pc_write=1. Next: JALRLINK.
- **JALRLINK**: A=01, B=10, add, result_src=10, reg_write=1. Next: FETCH.
- **LUI**: A=11, B=01, imm U, add. Next: ALUWB.
- **ILLEGAL**: all enables 0, illegal=1. Holds until reset.

## Timing
- One state per clock; state register updates on the rising edge.
- While rst_n=0 at an edge: next state is FETCH and illegal clears.
- Write enables are gated low in any cycle where rst_n=0.
- First FETCH is the cycle after rst_n rises.
- Reset mid-instruction abandons it; no partial write follows.
- Cycles per instruction:
  - load 5
  - store, R-type, I-type ALU, JAL, JALR, LUI: 4
  - branch, AUIPC: 3
- Outputs are combinational from state. In BRANCH, pc_write additionally depends on alu_zero / alu_lsb within the same cycle.
- opcode, funct3 and funct7b5 are sampled only in DECODE and later states. Their values during FETCH are don't-care.
- alu_src_a/b, imm_src and alu_control are held at defaults in states where the ALU is unused.

## Test plan
- Reset, then `add` (0110011, f3=000, f7b5=0): states FETCH→DECODE→EXECR→ALUWB→FETCH. alu_control=0000 in EXECR; reg_write=1 only in ALUWB.
- `sub` / `sra` / `srai` / `addi` with funct7b5=1: EXECR gives 0001 / 1011, EXECI gives 1011 / 0000 respectively.
- `lw`: 5 cycles; mem_write never asserts; result_src=01 with reg_write=1 in the 5th cycle. `sw`: mem_write=1 with adr_src=1 in the 4th cycle.
- `bne` in BRANCH: alu_zero=1 → pc_write=0; alu_zero=0 → pc_write=1. `bgeu` with alu_lsb=0 → pc_write=1; cycle 3 returns to FETCH.
- `jal`: pc_write asserts in FETCH and JAL; ALUWB writes the link. `jalr`: pc_write in JALR, reg_write in JALRLINK with result_src=10.
- Opcode 1111111, or branch funct3=010: enter ILLEGAL and stay with illegal=1 and no enables for 10+ cycles. rst_n=0 for one edge → FETCH, illegal=0. Reset asserted during MEMWRITE → no mem_write on that edge.
